decode_issue_stage: RTL and testbench

- Parametrised successor of the single-issue decode stage: decodes one RV32 instruction per cycle, reads operands, bypasses, and issues to either the single-cycle ALU path or an N-stage multiplier pipeline.
- Replaces hardwired per-stage multiplier valid/rd inputs with an internal MUL_STAGES-deep destination tracker.
- Adds x0 hazard suppression, a flush input and a bubble counter.
- Sits between fetch and the ALU/MUL execute stages.

---
 rtl/params_pkg.sv | 35 +++
 rtl/decode_issue_stage_if.sv | 53 +++++
 rtl/mul_dest_tracker.sv | 56 +++++
 rtl/decode_issue_stage.sv | 153 +++++++++++++++
 tb/tb_decode_issue_stage.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/params_pkg.sv
// Shared types and default widths for the decode/issue stage: RV32 instruction
// layout, the opcode subset this stage understands, and the MUL decode helper.
package params_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int ADDR_WIDTH_DEF     = 32;
   localparam int REGISTER_WIDTH_DEF = 5;
   localparam int SHAMT_WIDTH_DEF    = 5;
   localparam int MUL_STAGES_DEF     = 5;
   localparam int CNT_WIDTH_DEF      = 16;

   typedef enum logic [6:0] {
      OP_R         = 7'b0110011,
      OP_IMMEDIATE = 7'b0010011,
      OP_LOAD      = 7'b0000011,
      OP_STORE     = 7'b0100011,
      OP_BRANCH    = 7'b1100011,
      OP_JAL       = 7'b1101111,
      OP_AUIPC     = 7'b0010111
   } opcode_e;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instruction_t;

   function automatic logic is_mul_op(input instruction_t ins);
      return (ins.opcode == OP_R) && (ins.funct3 == 3'b000) && (ins.funct7 == 7'b0000001);
   endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Signal bundle around the decode/issue stage: fetch/WB/regfile inputs on the
// master side, issue outputs and status on the slave (stage) side.
interface decode_issue_stage_if
   import params_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int REGISTER_WIDTH = REGISTER_WIDTH_DEF,
   parameter int SHAMT_WIDTH    = SHAMT_WIDTH_DEF,
   parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) ();
   logic                      valid_i;
   logic                      flush_i;
   logic                      mem_stall_i;
   logic                      alu_done_i;
   logic                      wb_next_i;
   logic                      wb_reg_wr_en_i;
   logic [REGISTER_WIDTH-1:0] wb_wr_reg_i;
   logic [DATA_WIDTH-1:0]     wb_data_i;
   logic [DATA_WIDTH-1:0]     mul_result_i;
   logic [ADDR_WIDTH-1:0]     pc_i;
   instruction_t              instruction_i;
   logic [DATA_WIDTH-1:0]     rs1_data_i;
   logic [DATA_WIDTH-1:0]     rs2_data_i;
   logic                      stall_o;
   logic [REGISTER_WIDTH-1:0] rs1_o;
   logic [REGISTER_WIDTH-1:0] rs2_o;
   logic                      alu_valid_o;
   logic                      mul_valid_o;
   logic [REGISTER_WIDTH-1:0] wr_reg_o;
   logic [ADDR_WIDTH-1:0]     pc_o;
   logic [DATA_WIDTH-1:0]     rs1_data_o;
   logic [DATA_WIDTH-1:0]     rs2_data_o;
   logic [DATA_WIDTH-1:0]     imm_o;
   logic [SHAMT_WIDTH-1:0]    shamt_o;
   instruction_t              instruction_o;
   logic                      mul_busy_o;
   logic [CNT_WIDTH-1:0]      bubble_cnt_o;

   modport master (
      output valid_i, flush_i, mem_stall_i, alu_done_i, wb_next_i, wb_reg_wr_en_i,
             wb_wr_reg_i, wb_data_i, mul_result_i, pc_i, instruction_i, rs1_data_i, rs2_data_i,
      input  stall_o, rs1_o, rs2_o, alu_valid_o, mul_valid_o, wr_reg_o, pc_o, rs1_data_o,
             rs2_data_o, imm_o, shamt_o, instruction_o, mul_busy_o, bubble_cnt_o
   );

   modport slave (
      input  valid_i, flush_i, mem_stall_i, alu_done_i, wb_next_i, wb_reg_wr_en_i,
             wb_wr_reg_i, wb_data_i, mul_result_i, pc_i, instruction_i, rs1_data_i, rs2_data_i,
      output stall_o, rs1_o, rs2_o, alu_valid_o, mul_valid_o, wr_reg_o, pc_o, rs1_data_o,
             rs2_data_o, imm_o, shamt_o, instruction_o, mul_busy_o, bubble_cnt_o
   );
endinterface

// File: rtl/mul_dest_tracker.sv
// Shift register of {valid, rd} mirroring the multiplier pipeline; reports
// in-flight (not yet bypassable) and last-stage matches for both sources.
module mul_dest_tracker #(
   parameter int MUL_STAGES     = 5,
   parameter int REGISTER_WIDTH = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      push_i,
   input  logic [REGISTER_WIDTH-1:0] push_rd_i,
   input  logic [REGISTER_WIDTH-1:0] rs1_i,
   input  logic [REGISTER_WIDTH-1:0] rs2_i,
   output logic                      rs1_busy_o,
   output logic                      rs2_busy_o,
   output logic                      rs1_last_o,
   output logic                      rs2_last_o,
   output logic                      early_busy_o,
   output logic                      ls_busy_o,
   output logic                      busy_o
);
   logic [MUL_STAGES-1:0]     vld_q, vld_d;
   logic [REGISTER_WIDTH-1:0] rd_q [MUL_STAGES];
   logic [REGISTER_WIDTH-1:0] rd_d [MUL_STAGES];
   logic [MUL_STAGES-1:0]     rs1_hit, rs2_hit;

   for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_slot
      if (gi == 0) begin : g_head
         assign vld_d[gi] = push_i;
         assign rd_d[gi]  = push_rd_i;
      end else begin : g_body
         assign vld_d[gi] = vld_q[gi-1];
         assign rd_d[gi]  = rd_q[gi-1];
      end
      assign rs1_hit[gi] = vld_q[gi] && (rd_q[gi] == rs1_i);
      assign rs2_hit[gi] = vld_q[gi] && (rd_q[gi] == rs2_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= '0;
         for (int k = 0; k < MUL_STAGES; k++) rd_q[k] <= '0;
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < MUL_STAGES; k++) rd_q[k] <= rd_d[k];
      end
   end

   // Only the final stage carries a usable result; earlier stages are hazards.
   assign rs1_busy_o   = |rs1_hit[MUL_STAGES-2:0];
   assign rs2_busy_o   = |rs2_hit[MUL_STAGES-2:0];
   assign rs1_last_o   = rs1_hit[MUL_STAGES-1];
   assign rs2_last_o   = rs2_hit[MUL_STAGES-1];
   assign early_busy_o = |vld_q[MUL_STAGES-2:0];
   assign ls_busy_o    = vld_q[0] | vld_q[1];
   assign busy_o       = |vld_q;
endmodule

// File: rtl/decode_issue_stage.sv
// Decodes one RV32 instruction per cycle, resolves hazards/bypasses and issues
// it to the ALU path or the multiplier pipeline through registered outputs.
module decode_issue_stage
   import params_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int REGISTER_WIDTH = REGISTER_WIDTH_DEF,
   parameter int SHAMT_WIDTH    = SHAMT_WIDTH_DEF,
   parameter int MUL_STAGES     = MUL_STAGES_DEF,
   parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      valid_i,
   input  logic                      flush_i,
   input  logic                      mem_stall_i,
   input  logic                      alu_done_i,
   input  logic                      wb_next_i,
   input  logic                      wb_reg_wr_en_i,
   input  logic [REGISTER_WIDTH-1:0] wb_wr_reg_i,
   input  logic [DATA_WIDTH-1:0]     wb_data_i,
   input  logic [DATA_WIDTH-1:0]     mul_result_i,
   input  logic [ADDR_WIDTH-1:0]     pc_i,
   input  instruction_t              instruction_i,
   input  logic [DATA_WIDTH-1:0]     rs1_data_i,
   input  logic [DATA_WIDTH-1:0]     rs2_data_i,
   output logic                      stall_o,
   output logic [REGISTER_WIDTH-1:0] rs1_o,
   output logic [REGISTER_WIDTH-1:0] rs2_o,
   output logic                      alu_valid_o,
   output logic                      mul_valid_o,
   output logic [REGISTER_WIDTH-1:0] wr_reg_o,
   output logic [ADDR_WIDTH-1:0]     pc_o,
   output logic [DATA_WIDTH-1:0]     rs1_data_o,
   output logic [DATA_WIDTH-1:0]     rs2_data_o,
   output logic [DATA_WIDTH-1:0]     imm_o,
   output logic [SHAMT_WIDTH-1:0]    shamt_o,
   output instruction_t              instruction_o,
   output logic                      mul_busy_o,
   output logic [CNT_WIDTH-1:0]      bubble_cnt_o
);
   instruction_t          ins;
   logic [31:0]           raw;
   logic                  is_mul, reads_rs1, reads_rs2, writes_alu, is_mem;
   logic                  rs1_busy, rs2_busy, rs1_last, rs2_last, early_busy, ls_busy;
   logic                  raw_hazard, struct_stall, stall_d, load_en;
   logic                  alu_valid_d, mul_valid_d;
   logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd, imm_d;
   logic                  alu_valid_q, mul_valid_q;
   logic [CNT_WIDTH-1:0]  bubble_q;

   assign ins   = instruction_i;
   assign raw   = instruction_i;
   assign rs1_o = ins.rs1;
   assign rs2_o = ins.rs2;

   always_comb begin
      is_mul     = is_mul_op(ins);
      reads_rs1  = !(ins.opcode inside {OP_JAL, OP_AUIPC});
      reads_rs2  = !(ins.opcode inside {OP_JAL, OP_AUIPC, OP_LOAD, OP_IMMEDIATE});
      writes_alu = ((ins.opcode == OP_R) && !is_mul) || (ins.opcode inside {OP_IMMEDIATE, OP_JAL, OP_AUIPC});
      is_mem     = ins.opcode inside {OP_LOAD, OP_STORE};
   end

   mul_dest_tracker #(
      .MUL_STAGES    (MUL_STAGES),
      .REGISTER_WIDTH(REGISTER_WIDTH)
   ) u_tracker (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (mul_valid_d),
      .push_rd_i   (ins.rd),
      .rs1_i       (ins.rs1),
      .rs2_i       (ins.rs2),
      .rs1_busy_o  (rs1_busy),
      .rs2_busy_o  (rs2_busy),
      .rs1_last_o  (rs1_last),
      .rs2_last_o  (rs2_last),
      .early_busy_o(early_busy),
      .ls_busy_o   (ls_busy),
      .busy_o      (mul_busy_o)
   );

   always_comb begin
      raw_hazard   = valid_i && ((reads_rs1 && (ins.rs1 != '0) && rs1_busy) ||
                                 (reads_rs2 && (ins.rs2 != '0) && rs2_busy));
      struct_stall = (writes_alu && (wb_next_i || early_busy || (alu_valid_q && !alu_done_i))) ||
                     (is_mem && ls_busy);
      stall_d      = valid_i && !flush_i && (mem_stall_i || raw_hazard || struct_stall);
      load_en      = !flush_i && !stall_d;
      alu_valid_d  = load_en && valid_i && !is_mul;
      mul_valid_d  = load_en && valid_i && is_mul;
   end

   assign stall_o = stall_d;

   // The last multiplier stage outranks WB: it holds the younger write to the same register.
   always_comb begin
      rs1_fwd = rs1_data_i;
      if (ins.rs1 == '0)                                   rs1_fwd = '0;
      else if (rs1_last)                                   rs1_fwd = mul_result_i;
      else if (wb_reg_wr_en_i && (wb_wr_reg_i == ins.rs1)) rs1_fwd = wb_data_i;
      rs2_fwd = rs2_data_i;
      if (ins.rs2 == '0)                                   rs2_fwd = '0;
      else if (rs2_last)                                   rs2_fwd = mul_result_i;
      else if (wb_reg_wr_en_i && (wb_wr_reg_i == ins.rs2)) rs2_fwd = wb_data_i;
   end

   always_comb begin
      imm_d = '0;
      case (ins.opcode)
         OP_LOAD, OP_IMMEDIATE: imm_d = DATA_WIDTH'($signed(raw[31:20]));
         OP_STORE:  imm_d = DATA_WIDTH'($signed({raw[31:25], raw[11:7]}));
         OP_BRANCH: imm_d = DATA_WIDTH'($signed({raw[31], raw[7], raw[30:25], raw[11:8], 1'b0}));
         OP_JAL:    imm_d = DATA_WIDTH'($signed({raw[31], raw[19:12], raw[20], raw[30:21], 1'b0}));
         OP_AUIPC:  imm_d = DATA_WIDTH'($signed({raw[31:12], 12'b0}));
         default:   imm_d = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alu_valid_q   <= 1'b0;
         mul_valid_q   <= 1'b0;
         wr_reg_o      <= '0;
         pc_o          <= '0;
         rs1_data_o    <= '0;
         rs2_data_o    <= '0;
         imm_o         <= '0;
         shamt_o       <= '0;
         instruction_o <= '0;
         bubble_q      <= '0;
      end else begin
         alu_valid_q <= alu_valid_d;
         mul_valid_q <= mul_valid_d;
         if (load_en) begin
            wr_reg_o      <= ins.rd;
            pc_o          <= pc_i;
            rs1_data_o    <= rs1_fwd;
            rs2_data_o    <= rs2_fwd;
            imm_o         <= imm_d;
            shamt_o       <= (ins.opcode == OP_IMMEDIATE) ? SHAMT_WIDTH'({raw[25], ins.rs2}) : '0;
            instruction_o <= ins;
         end
         if (stall_d && (bubble_q != '1)) bubble_q <= bubble_q + 1'b1;
      end
   end

   assign alu_valid_o  = alu_valid_q;
   assign mul_valid_o  = mul_valid_q;
   assign bubble_cnt_o = bubble_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench: stimulus pushes the expected issue record into a queue, an
// independent monitor pops and compares whenever the stage issues.
module tb_decode_issue_stage;
   import params_pkg::*;

   localparam logic [31:0] RF1 = 32'hAAAA_0001;
   localparam logic [31:0] RF2 = 32'hBBBB_0002;

   typedef struct {
      logic        is_mul;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  sh;
      logic [31:0] ins;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   decode_issue_stage_if bus ();

   decode_issue_stage dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (bus.valid_i),
      .flush_i       (bus.flush_i),
      .mem_stall_i   (bus.mem_stall_i),
      .alu_done_i    (bus.alu_done_i),
      .wb_next_i     (bus.wb_next_i),
      .wb_reg_wr_en_i(bus.wb_reg_wr_en_i),
      .wb_wr_reg_i   (bus.wb_wr_reg_i),
      .wb_data_i     (bus.wb_data_i),
      .mul_result_i  (bus.mul_result_i),
      .pc_i          (bus.pc_i),
      .instruction_i (bus.instruction_i),
      .rs1_data_i    (bus.rs1_data_i),
      .rs2_data_i    (bus.rs2_data_i),
      .stall_o       (bus.stall_o),
      .rs1_o         (bus.rs1_o),
      .rs2_o         (bus.rs2_o),
      .alu_valid_o   (bus.alu_valid_o),
      .mul_valid_o   (bus.mul_valid_o),
      .wr_reg_o      (bus.wr_reg_o),
      .pc_o          (bus.pc_o),
      .rs1_data_o    (bus.rs1_data_o),
      .rs2_data_o    (bus.rs2_data_o),
      .imm_o         (bus.imm_o),
      .shamt_o       (bus.shamt_o),
      .instruction_o (bus.instruction_o),
      .mul_busy_o    (bus.mul_busy_o),
      .bubble_cnt_o  (bus.bubble_cnt_o)
   );

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic m, input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] sh, input logic [31:0] ins);
      exp_t e;
      e.is_mul = m; e.pc = pc; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.sh = sh; e.ins = ins;
      exp_q.push_back(e);
   endtask

   // Present an instruction until accepted; entered and left at posedge+1.
   task automatic send(input string name, input logic [31:0] ins, input logic [31:0] pc, input int exp_stalls);
      int n;
      bus.instruction_i = ins;
      bus.pc_i          = pc;
      bus.valid_i       = 1'b1;
      n = 0;
      @(negedge clk);
      while (bus.stall_o && n < 64) begin
         n++;
         @(negedge clk);
      end
      check({name, "_stalls"}, n, exp_stalls);
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (bus.alu_valid_o || bus.mul_valid_o) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_issue: got pc=%h alu=%b mul=%b expected no issue",
                     bus.pc_o, bus.alu_valid_o, bus.mul_valid_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.mul_valid_o !== e.is_mul || bus.alu_valid_o !== !e.is_mul || bus.pc_o !== e.pc ||
                bus.wr_reg_o !== e.rd || bus.rs1_data_o !== e.a || bus.rs2_data_o !== e.b ||
                bus.imm_o !== e.imm || bus.shamt_o !== e.sh || bus.instruction_o !== e.ins) begin
               fails++;
               $display("[TB] FAIL issue: got mul=%b pc=%h rd=%0d a=%h b=%h imm=%h sh=%0d ins=%h expected mul=%b pc=%h rd=%0d a=%h b=%h imm=%h sh=%0d ins=%h",
                        bus.mul_valid_o, bus.pc_o, bus.wr_reg_o, bus.rs1_data_o, bus.rs2_data_o, bus.imm_o,
                        bus.shamt_o, bus.instruction_o, e.is_mul, e.pc, e.rd, e.a, e.b, e.imm, e.sh, e.ins);
            end else begin
               $display("[TB] issue pc=%h mul=%b rd=%0d a=%h b=%h imm=%h ok", e.pc, e.is_mul, e.rd, e.a, e.b, e.imm);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] i;
      bus.valid_i = 0; bus.flush_i = 0; bus.mem_stall_i = 0; bus.alu_done_i = 1;
      bus.wb_next_i = 0; bus.wb_reg_wr_en_i = 0; bus.wb_wr_reg_i = '0; bus.wb_data_i = '0;
      bus.mul_result_i = 32'h1234_5678; bus.pc_i = '0; bus.instruction_i = '0;
      bus.rs1_data_i = RF1; bus.rs2_data_i = RF2;
      repeat (3) @(posedge clk);
      #1;
      check("rst_alu_valid", bus.alu_valid_o, 0);
      check("rst_mul_valid", bus.mul_valid_o, 0);
      check("rst_mul_busy", bus.mul_busy_o, 0);
      check("rst_bubble", bus.bubble_cnt_o, 0);
      check("rst_pc", bus.pc_o, 0);
      check("rst_imm", bus.imm_o, 0);
      rst = 0;

      // MUL x5 followed by a dependent ADD: waits until x5 reaches the last stage.
      i = enc_r(7'd1, 5'd2, 5'd1, 5'd5);
      push(1, 32'h100, 5'd5, RF1, RF2, 0, 0, i);
      send("mul_x5", i, 32'h100, 0);
      i = enc_r(7'd0, 5'd3, 5'd5, 5'd6);
      push(0, 32'h104, 5'd6, 32'h1234_5678, RF2, 0, 0, i);
      send("add_raw_x5", i, 32'h104, 4);
      check("bubble_after_raw", bus.bubble_cnt_o, 4);
      idle(6);

      // MUL x0: no RAW on x0, but the ADD still waits on the busy pipe.
      i = enc_r(7'd1, 5'd2, 5'd1, 5'd0);
      push(1, 32'h200, 5'd0, RF1, RF2, 0, 0, i);
      send("mul_x0", i, 32'h200, 0);
      i = enc_r(7'd0, 5'd3, 5'd0, 5'd6);
      push(0, 32'h204, 5'd6, 0, RF2, 0, 0, i);
      send("add_x0_struct", i, 32'h204, 4);
      check("bubble_after_x0", bus.bubble_cnt_o, 8);
      idle(6);

      // WB bypass, then last-stage bypass overriding WB.
      i = enc_i(12'd12, 5'd0, 3'b000, 5'd7, OP_IMMEDIATE);
      push(0, 32'h300, 5'd7, 0, RF2, 32'd12, 5'd12, i);
      send("addi_x7", i, 32'h300, 0);
      bus.wb_reg_wr_en_i = 1; bus.wb_wr_reg_i = 5'd7; bus.wb_data_i = 32'h0000_DEAD;
      i = enc_r(7'd0, 5'd3, 5'd7, 5'd8);
      push(0, 32'h304, 5'd8, 32'h0000_DEAD, RF2, 0, 0, i);
      send("add_wb_byp", i, 32'h304, 0);
      bus.mul_result_i = 32'h0000_BEEF;
      i = enc_r(7'd1, 5'd2, 5'd1, 5'd7);
      push(1, 32'h308, 5'd7, RF1, RF2, 0, 0, i);
      send("mul_x7", i, 32'h308, 0);
      i = enc_r(7'd0, 5'd3, 5'd7, 5'd9);
      push(0, 32'h30C, 5'd9, 32'h0000_BEEF, RF2, 0, 0, i);
      send("add_last_byp", i, 32'h30C, 4);
      bus.wb_reg_wr_en_i = 0;
      check("bubble_after_byp", bus.bubble_cnt_o, 12);
      idle(6);

      // SW, MUL, then LW stalled behind the MUL and killed by a flush.
      i = {7'd0, 5'd3, 5'd4, 3'b010, 5'd8, 7'b0100011};
      push(0, 32'h400, 5'd8, RF1, RF2, 32'd8, 0, i);
      send("sw", i, 32'h400, 0);
      i = enc_r(7'd1, 5'd2, 5'd1, 5'd10);
      push(1, 32'h404, 5'd10, RF1, RF2, 0, 0, i);
      send("mul_x10", i, 32'h404, 0);
      bus.instruction_i = enc_i(12'd4, 5'd4, 3'b010, 5'd11, OP_LOAD);
      bus.pc_i = 32'h408;
      bus.valid_i = 1;
      @(negedge clk);
      check("lw_stall_slot0", bus.stall_o, 1);
      @(posedge clk);
      #1;
      bus.flush_i = 1;
      @(negedge clk);
      check("flush_forces_no_stall", bus.stall_o, 0);
      @(posedge clk);
      #1;
      bus.flush_i = 0;
      bus.valid_i = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("lw_dropped", bus.alu_valid_o, 0);
      end
      check("bubble_after_flush", bus.bubble_cnt_o, 13);
      idle(6);

      // Immediate decode: BEQ -8, AUIPC 0x12345, SLLI 31.
      i = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1100, 1'b1, 7'b1100011};
      push(0, 32'h500, 5'd25, RF1, RF2, 32'hFFFF_FFF8, 0, i);
      send("beq", i, 32'h500, 0);
      i = {20'h12345, 5'd12, 7'b0010111};
      push(0, 32'h504, 5'd12, RF1, RF2, 32'h1234_5000, 0, i);
      send("auipc", i, 32'h504, 0);
      i = enc_i(12'd31, 5'd1, 3'b001, 5'd13, OP_IMMEDIATE);
      push(0, 32'h508, 5'd13, RF1, RF2, 32'd31, 5'd31, i);
      send("slli", i, 32'h508, 0);
      idle(6);

      // Reset with three multiplies in flight.
      for (int k = 0; k < 3; k++) begin
         i = enc_r(7'd1, 5'd2, 5'd1, 5'(14 + k));
         push(1, 32'h600 + 32'(4 * k), 5'(14 + k), RF1, RF2, 0, 0, i);
         send("mul_inflight", i, 32'h600 + 32'(4 * k), 0);
      end
      check("mul_busy_before_rst", bus.mul_busy_o, 1);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      check("midrst_mul_busy", bus.mul_busy_o, 0);
      check("midrst_alu_valid", bus.alu_valid_o, 0);
      check("midrst_mul_valid", bus.mul_valid_o, 0);
      check("midrst_bubble", bus.bubble_cnt_o, 0);
      @(posedge clk);
      #1;
      i = enc_r(7'd0, 5'd3, 5'd14, 5'd17);
      push(0, 32'h700, 5'd17, RF1, RF2, 0, 0, i);
      send("add_after_rst", i, 32'h700, 0);

      // Structural stalls: ALU result outstanding, then WB port claimed.
      bus.alu_done_i = 0;
      bus.instruction_i = enc_r(7'd0, 5'd3, 5'd1, 5'd18);
      bus.pc_i = 32'h704;
      bus.valid_i = 1;
      @(negedge clk);
      check("alu_not_done_stall", bus.stall_o, 1);
      @(posedge clk);
      #1;
      bus.alu_done_i = 1;
      i = enc_r(7'd0, 5'd3, 5'd1, 5'd18);
      push(0, 32'h704, 5'd18, RF1, RF2, 0, 0, i);
      send("add_x18", i, 32'h704, 0);
      bus.wb_next_i = 1;
      bus.instruction_i = enc_r(7'd0, 5'd3, 5'd1, 5'd19);
      bus.pc_i = 32'h708;
      bus.valid_i = 1;
      @(negedge clk);
      check("wb_next_stall", bus.stall_o, 1);
      @(posedge clk);
      #1;
      bus.wb_next_i = 0;
      i = enc_r(7'd0, 5'd3, 5'd1, 5'd19);
      push(0, 32'h708, 5'd19, RF1, RF2, 0, 0, i);
      send("add_x19", i, 32'h708, 0);
      check("bubble_structural", bus.bubble_cnt_o, 2);
      idle(4);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
